ps2_kbd_matrix: RTL and testbench
=================================

// Module: ps2_kbd_matrix
// PURPOSE
//  PS/2 keyboard receiver and Z88 key-matrix builder. Sits upstream of the blink keyboard input.
//  - Samples the raw PS/2 clock/data lines and assembles 11-bit device-to-host frames.
//  - Decodes set-2 make/break/E0 sequences and maintains a 64-bit active-low matrix (kbmat).
//  - Blink reads kbmat directly when the Z80 scans keyboard rows.
// PARAMETERS
//  CLK_HZ      25175000  system clock frequency; used to derive the timeout count
//  TIMEOUT_US  2000      inter-bit watchdog in microseconds; partial frame discarded on expiry
//  SYNC_STAGES 2         synchroniser depth for ps2clk/ps2dat (min 2)
// PORTS
//  clk        in   1   system clock (25.175 MHz, shared with VGA)
//  reset_n    in   1   asynchronous active-low reset; driven from blink rout_n
//  ps2clk     in   1   raw PS/2 clock, asynchronous, idle high
//  ps2dat     in   1   raw PS/2 data, asynchronous, idle high
//  kbmat_out  out  64  key matrix, bit = row*8+col, 0 = key pressed
//  scan_vld   out  1   one-cycle pulse per good frame
//  scan_code  out  8   last good frame byte (valid with scan_vld, held after)
//  frame_err  out  1   one-cycle pulse on parity/start/stop error or timeout
// BEHAVIOUR
//  Reset values:
//  - kbmat_out = 64'hFFFF_FFFF_FFFF_FFFF; scan_code = 0; scan_vld = 0; frame_err = 0.
//  - All FSMs in IDLE; break/ext flags cleared.
//  Input sampling:
//  - ps2clk and ps2dat pass through SYNC_STAGES flops each.
//  - A falling edge is sync'd clk 1->0. Data is sampled on that cycle.
//  RX FSM: IDLE -> DATA(8) -> PARITY -> STOP -> IDLE.
//  - IDLE: on fall with dat=0 go to DATA, bitcnt=0. A fall with dat=1 is a start error:
//    pulse frame_err, stay in IDLE.
//  - DATA: shift LSB first; after bit 7 go to PARITY.
//  - PARITY: require odd parity over data+parity; otherwise flag error.
//  - STOP: require dat=1. On success, one cycle later: scan_code<=byte, scan_vld=1.
//    Any error pulses frame_err instead and discards the byte. Both cases return to IDLE.
//  - Watchdog: counter reloads to CLK_HZ/1e6*TIMEOUT_US on each fall and counts down
//    outside IDLE. On reaching 0: pulse frame_err, go to IDLE.
//  Decode FSM (runs on scan_vld):
//  - E0 -> set ext. F0 -> set brk. E1 -> swallow the next 7 bytes (Pause); kbmat unchanged.
//  - Any other byte: look up {ext,code} in the map.
//    - Hit: clear bit on make, set bit on break.
//    - Miss: ignore.
//    - Either way clear ext and brk.
//  - AA (BAT ok) and FA/FE: ignored, flags untouched.
//  - The kbmat update is visible on the cycle after scan_vld (latency 1).
//  Map (combinational case). Required entries:
//  - 1C(A)->52; 5A(Enter)->6; 12(LShift)->54; 59(RShift)->63; 29(Space)->46.
//  - 66(Bksp)->7; 76(Esc)->61; 14(LCtrl)->60 (Diamond); E0 14(RCtrl)->60.
//  - E0 75/72/6B/74 (arrows)->11/3/19/27.
//  - Remaining alphanumerics per the team Z88 matrix table.
//  - Several PS/2 keys may share one bit; press/release is last-event-wins.
//  Boundary conditions:
//  - Extra edges while in IDLE with dat=1 count as errors only. Reset mid-frame aborts
//    immediately with no pulse.
//  - If a frame completes in the same cycle the watchdog expires, the completion wins.
//  - Simultaneous make of different keys is sequential by nature (one byte per frame).
//  - No host-to-device transmit; the block never drives ps2clk/ps2dat.
// TESTING
//  1. Reset: assert reset_n=0 mid-frame -> kbmat_out=all 1s, no scan_vld, and the next
//     frame decodes cleanly.
//  2. Frame 1C with parity 0 and stop 1 at 12 kHz -> scan_vld pulse, scan_code=8'h1C,
//     bit 52 goes 0. Then F0,1C -> bit 52 back to 1.
//  3. Bad parity on 8'h5A -> frame_err pulse, scan_vld=0, kbmat_out unchanged.
//  4. Stop after 5 data bits for more than 2 ms -> frame_err once. Then a full 8'h29
//     frame -> bit 46 = 0.
//  5. E0 75 -> bit 11 = 0; E0 F0 75 -> bit 11 = 1; plain 75 (keypad 8) -> no change.
//  6. E1 14 77 E1 F0 14 F0 77 then 12 -> only bit 54 cleared; start bit high -> frame_err.

Source files
------------

// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 keyboard receiver that maintains the Z88 active-low key matrix.
// The raw ps2clk/ps2dat lines are only ever read; this block never drives them.
module ps2_kbd_matrix #(
  parameter int CLK_HZ      = 25175000,
  parameter int TIMEOUT_US  = 2000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2clk,
  input  logic        ps2dat,
  output logic [63:0] kbmat_out,
  output logic        scan_vld,
  output logic [7:0]  scan_code,
  output logic        frame_err
);

  localparam int WD_LOAD = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int WD_W    = $clog2(WD_LOAD + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic {DEC_NORM, DEC_SKIP} dec_state_t;

  logic [SYNC_STAGES-1:0] clk_sync_reg, dat_sync_reg;
  logic                   clk_prev_reg;
  logic                   ps2clk_s, ps2dat_s, fall;

  rx_state_t   rx_state_reg, rx_state_next;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        par_ok_reg;
  logic [WD_W-1:0] wd_cnt_reg;
  logic        wd_expired, done_next, err_next;

  dec_state_t  dec_state_reg, dec_state_next;
  logic [2:0]  skip_cnt_reg, skip_cnt_next;
  logic        ext_reg, ext_next, brk_reg, brk_next;
  logic [63:0] kbmat_reg, kbmat_next;
  logic        map_hit;
  logic [5:0]  map_idx;

  // Line synchronisers idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg <= '1;
      dat_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2clk};
      dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2dat};
      clk_prev_reg <= ps2clk_s;
    end
  end

  assign ps2clk_s   = clk_sync_reg[SYNC_STAGES-1];
  assign ps2dat_s   = dat_sync_reg[SYNC_STAGES-1];
  assign fall       = clk_prev_reg & ~ps2clk_s;
  // A falling edge reloads the watchdog, so a completing frame beats expiry.
  assign wd_expired = (rx_state_reg != RX_IDLE) && (wd_cnt_reg == '0) && !fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_state_reg <= RX_IDLE;
    else          rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    if (wd_expired) begin
      rx_state_next = RX_IDLE;
    end else if (fall) begin
      case (rx_state_reg)
        RX_IDLE:   if (!ps2dat_s) rx_state_next = RX_DATA;
        RX_DATA:   if (bit_cnt_reg == 3'd7) rx_state_next = RX_PARITY;
        RX_PARITY: rx_state_next = RX_STOP;
        default:   rx_state_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    done_next = 1'b0;
    err_next  = 1'b0;
    if (wd_expired) begin
      err_next = 1'b1;
    end else if (fall) begin
      if (rx_state_reg == RX_IDLE && ps2dat_s) err_next = 1'b1;
      if (rx_state_reg == RX_STOP) begin
        done_next = ps2dat_s & par_ok_reg;
        err_next  = ~(ps2dat_s & par_ok_reg);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_ok_reg  <= 1'b0;
      wd_cnt_reg  <= '0;
      scan_vld    <= 1'b0;
      frame_err   <= 1'b0;
      scan_code   <= '0;
    end else begin
      if (fall)
        wd_cnt_reg <= WD_W'(WD_LOAD);
      else if (rx_state_reg != RX_IDLE && wd_cnt_reg != '0)
        wd_cnt_reg <= wd_cnt_reg - 1'b1;
      if (fall) begin
        case (rx_state_reg)
          RX_IDLE:   bit_cnt_reg <= '0;
          RX_DATA: begin
            shift_reg   <= {ps2dat_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
          RX_PARITY: par_ok_reg <= ^{shift_reg, ps2dat_s};
          default:   ;
        endcase
      end
      scan_vld  <= done_next;
      frame_err <= err_next;
      if (done_next) scan_code <= shift_reg;
    end
  end

  // Set-2 code (with E0 prefix in bit 8) to matrix bit, row*8+col.
  always_comb begin
    map_hit = 1'b1;
    map_idx = '0;
    case ({ext_reg, scan_code})
      9'h01C: map_idx = 6'd52;  9'h05A: map_idx = 6'd6;   9'h012: map_idx = 6'd54;
      9'h059: map_idx = 6'd63;  9'h029: map_idx = 6'd46;  9'h066: map_idx = 6'd7;
      9'h076: map_idx = 6'd61;  9'h014: map_idx = 6'd60;  9'h114: map_idx = 6'd60;
      9'h175: map_idx = 6'd11;  9'h172: map_idx = 6'd3;   9'h16B: map_idx = 6'd19;
      9'h174: map_idx = 6'd27;
      9'h016: map_idx = 6'd0;   9'h01E: map_idx = 6'd1;   9'h026: map_idx = 6'd2;
      9'h025: map_idx = 6'd4;   9'h02E: map_idx = 6'd5;   9'h036: map_idx = 6'd8;
      9'h03D: map_idx = 6'd9;   9'h03E: map_idx = 6'd10;  9'h046: map_idx = 6'd12;
      9'h045: map_idx = 6'd13;  9'h015: map_idx = 6'd14;  9'h01D: map_idx = 6'd15;
      9'h024: map_idx = 6'd16;  9'h02D: map_idx = 6'd17;  9'h02C: map_idx = 6'd18;
      9'h035: map_idx = 6'd20;  9'h03C: map_idx = 6'd21;  9'h043: map_idx = 6'd22;
      9'h044: map_idx = 6'd23;  9'h04D: map_idx = 6'd24;  9'h01B: map_idx = 6'd25;
      9'h023: map_idx = 6'd26;  9'h02B: map_idx = 6'd28;  9'h034: map_idx = 6'd29;
      9'h033: map_idx = 6'd30;  9'h03B: map_idx = 6'd31;  9'h042: map_idx = 6'd32;
      9'h04B: map_idx = 6'd33;  9'h01A: map_idx = 6'd34;  9'h022: map_idx = 6'd35;
      9'h021: map_idx = 6'd36;  9'h02A: map_idx = 6'd37;  9'h032: map_idx = 6'd38;
      9'h031: map_idx = 6'd39;  9'h03A: map_idx = 6'd40;
      default: map_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_state_reg <= DEC_NORM;
      skip_cnt_reg  <= '0;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
      kbmat_reg     <= '1;
    end else begin
      dec_state_reg <= dec_state_next;
      skip_cnt_reg  <= skip_cnt_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
      kbmat_reg     <= kbmat_next;
    end
  end

  always_comb begin
    dec_state_next = dec_state_reg;
    if (scan_vld) begin
      if (dec_state_reg == DEC_NORM && scan_code == 8'hE1) dec_state_next = DEC_SKIP;
      if (dec_state_reg == DEC_SKIP && skip_cnt_reg == 3'd1) dec_state_next = DEC_NORM;
    end
  end

  always_comb begin
    skip_cnt_next = skip_cnt_reg;
    ext_next      = ext_reg;
    brk_next      = brk_reg;
    kbmat_next    = kbmat_reg;
    if (scan_vld) begin
      if (dec_state_reg == DEC_SKIP) begin
        skip_cnt_next = skip_cnt_reg - 3'd1;
      end else begin
        case (scan_code)
          8'hE0: ext_next = 1'b1;
          8'hF0: brk_next = 1'b1;
          8'hE1: skip_cnt_next = 3'd7;  // Pause: E1 plus seven trailing bytes
          8'hAA, 8'hFA, 8'hFE: ;
          default: begin
            if (map_hit) kbmat_next[map_idx] = brk_reg;
            ext_next = 1'b0;
            brk_next = 1'b0;
          end
        endcase
      end
    end
  end

  assign kbmat_out = kbmat_reg;

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Directed bench for ps2_kbd_matrix: 1 MHz system clock, ~12 kHz PS/2 clock, 2 ms watchdog.
`timescale 1ns/1ps
module tb_ps2_kbd_matrix;

  localparam int HALF = 42;  // PS/2 half period in system clocks
  localparam logic [63:0] ONES = '1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2clk = 1'b1;
  logic        ps2dat = 1'b1;
  logic [63:0] kbmat_out;
  logic        scan_vld;
  logic [7:0]  scan_code;
  logic        frame_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  logic        vld_prev = 1'b0;
  logic [63:0] kb_at_vld = '0;
  logic [63:0] kb_after_vld = '0;

  ps2_kbd_matrix #(.CLK_HZ(1000000), .TIMEOUT_US(2000), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .ps2clk(ps2clk), .ps2dat(ps2dat),
    .kbmat_out(kbmat_out), .scan_vld(scan_vld), .scan_code(scan_code), .frame_err(frame_err)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (vld_prev) kb_after_vld = kbmat_out;
    vld_prev = scan_vld;
    if (scan_vld) begin
      vld_cnt++;
      kb_at_vld = kbmat_out;
    end
    if (frame_err) err_cnt++;
  end

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2dat = bits[i];
      repeat (HALF) @(posedge clk);
      ps2clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2clk = 1'b1;
    end
    ps2dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    $display("tx frame %h%s", b, bad_par ? " (bad parity)" : "");
    ps2_bits(f, 11);
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int v0, e0;
    repeat (5) @(negedge clk);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL reset_kbmat got %h want %h", kbmat_out, ONES); else pass_cnt++;
    total_cnt++; if (scan_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", scan_vld); else pass_cnt++;
    total_cnt++; if (scan_code !== 8'h00) $display("FAIL reset_code got %h want 00", scan_code); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_err got %b want 0", frame_err); else pass_cnt++;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    v0 = vld_cnt; e0 = err_cnt;
    $display("tx partial frame then reset");
    ps2_bits(11'b111_0011_0110, 4);
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL midreset_kbmat got %h want %h", kbmat_out, ONES); else pass_cnt++;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++; if (vld_cnt - v0 !== 0) $display("FAIL midreset_vld got %0d want 0", vld_cnt - v0); else pass_cnt++;
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL midreset_err got %0d want 0", err_cnt - e0); else pass_cnt++;
    send_byte(8'h66, 1'b0);
    total_cnt++; if (scan_code !== 8'h66) $display("FAIL postreset_code got %h want 66", scan_code); else pass_cnt++;
    total_cnt++; if (kbmat_out !== ~(64'd1 << 7)) $display("FAIL postreset_kbmat got %h want %h", kbmat_out, ~(64'd1 << 7)); else pass_cnt++;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h66, 1'b0);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL postreset_release got %h want %h", kbmat_out, ONES); else pass_cnt++;
  endtask

  task automatic test_make_break();
    int v0;
    v0 = vld_cnt;
    send_byte(8'h1C, 1'b0);
    total_cnt++; if (vld_cnt - v0 !== 1) $display("FAIL make_vld_count got %0d want 1", vld_cnt - v0); else pass_cnt++;
    total_cnt++; if (scan_code !== 8'h1C) $display("FAIL make_code got %h want 1c", scan_code); else pass_cnt++;
    total_cnt++; if (kb_at_vld !== ONES) $display("FAIL make_latency got %h want %h", kb_at_vld, ONES); else pass_cnt++;
    total_cnt++; if (kb_after_vld !== ~(64'd1 << 52)) $display("FAIL make_after got %h want %h", kb_after_vld, ~(64'd1 << 52)); else pass_cnt++;
    send_byte(8'hF0, 1'b0);
    total_cnt++; if (kbmat_out !== ~(64'd1 << 52)) $display("FAIL f0_hold got %h want %h", kbmat_out, ~(64'd1 << 52)); else pass_cnt++;
    send_byte(8'h1C, 1'b0);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL break_a got %h want %h", kbmat_out, ONES); else pass_cnt++;
  endtask

  task automatic test_bad_parity();
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'h5A, 1'b1);
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL parity_err got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (vld_cnt - v0 !== 0) $display("FAIL parity_vld got %0d want 0", vld_cnt - v0); else pass_cnt++;
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL parity_kbmat got %h want %h", kbmat_out, ONES); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt;
    $display("tx start plus 5 data bits then stall");
    ps2_bits(11'b000_0010_1010, 6);
    repeat (1500) @(negedge clk);
    total_cnt++; if (err_cnt - e0 !== 0) $display("FAIL timeout_early got %0d want 0", err_cnt - e0); else pass_cnt++;
    repeat (1000) @(negedge clk);
    total_cnt++; if (err_cnt - e0 !== 1) $display("FAIL timeout_err got %0d want 1", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (vld_cnt - v0 !== 0) $display("FAIL timeout_vld got %0d want 0", vld_cnt - v0); else pass_cnt++;
    send_byte(8'h29, 1'b0);
    total_cnt++; if (kbmat_out !== ~(64'd1 << 46)) $display("FAIL timeout_space got %h want %h", kbmat_out, ~(64'd1 << 46)); else pass_cnt++;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h29, 1'b0);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL timeout_release got %h want %h", kbmat_out, ONES); else pass_cnt++;
  endtask

  task automatic test_extended();
    int v0;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    total_cnt++; if (kbmat_out !== ~(64'd1 << 11)) $display("FAIL ext_up got %h want %h", kbmat_out, ~(64'd1 << 11)); else pass_cnt++;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL ext_up_release got %h want %h", kbmat_out, ONES); else pass_cnt++;
    v0 = vld_cnt;
    send_byte(8'h75, 1'b0);
    total_cnt++; if (vld_cnt - v0 !== 1) $display("FAIL kp8_vld got %0d want 1", vld_cnt - v0); else pass_cnt++;
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL kp8_nochange got %h want %h", kbmat_out, ONES); else pass_cnt++;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    total_cnt++; if (kbmat_out !== ~(64'd1 << 19)) $display("FAIL ext_left got %h want %h", kbmat_out, ~(64'd1 << 19)); else pass_cnt++;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL ext_left_release got %h want %h", kbmat_out, ONES); else pass_cnt++;
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    int e0, v0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b0);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL pause_swallow got %h want %h", kbmat_out, ONES); else pass_cnt++;
    send_byte(8'h12, 1'b0);
    total_cnt++; if (kbmat_out !== ~(64'd1 << 54)) $display("FAIL pause_then_lshift got %h want %h", kbmat_out, ~(64'd1 << 54)); else pass_cnt++;
    e0 = err_cnt; v0 = vld_cnt;
    $display("tx two lone edges with data high");
    ps2_bits(11'h7FF, 2);
    repeat (10) @(negedge clk);
    total_cnt++; if (err_cnt - e0 !== 2) $display("FAIL start_high_err got %0d want 2", err_cnt - e0); else pass_cnt++;
    total_cnt++; if (vld_cnt - v0 !== 0) $display("FAIL start_high_vld got %0d want 0", vld_cnt - v0); else pass_cnt++;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h12, 1'b0);
    total_cnt++; if (kbmat_out !== ONES) $display("FAIL lshift_release got %h want %h", kbmat_out, ONES); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_bad_parity();
    test_timeout();
    test_extended();
    test_pause();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
